// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU controller: widths, opcodes, ALU op codes,
// FSM states and instruction field positions.
package alu_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int RA_W   = 3;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS_MSB  = 8;
  localparam int RS_LSB  = 6;
  localparam int RT_MSB  = 5;
  localparam int RT_LSB  = 3;
  localparam int IMM_MSB = 8;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SHL  = 4'h2;
  localparam logic [3:0] OP_SHR  = 4'h3;
  localparam logic [3:0] OP_SAR  = 4'h4;
  localparam logic [3:0] OP_SLA  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_NAND = 4'h7;
  localparam logic [3:0] OP_NOP  = 4'h8;
  localparam logic [3:0] OP_LI   = 4'h9;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_SHL  = 3'd2;
  localparam logic [2:0] ALU_SHR  = 3'd3;
  localparam logic [2:0] ALU_SAR  = 3'd4;
  localparam logic [2:0] ALU_SLA  = 3'd5;
  localparam logic [2:0] ALU_OR   = 3'd6;
  localparam logic [2:0] ALU_NAND = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  function automatic logic [DATA_W-1:0] sext9(input logic [8:0] v);
    return {{(DATA_W-9){v[8]}}, v};
  endfunction

endpackage

// File: rtl/alu16.sv
// 16-bit ALU evaluated on the falling clock edge; the sequencer gives it
// half a cycle between registering operands and sampling the result.
module alu16
  import alu_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [2:0]        i_op,
  output logic [DATA_W-1:0] o_out,
  output logic              o_zerof
);

  logic [DATA_W-1:0] w_res;
  logic [DATA_W-1:0] r_out;
  logic              r_zerof;

  always_comb begin
    w_res = '0;
    case (i_op)
      ALU_ADD:  w_res = i_a + i_b;
      ALU_SUB:  w_res = i_a - i_b;
      ALU_SHL:  w_res = i_b << i_a;
      ALU_SHR:  w_res = i_b >> i_a;
      ALU_SAR:  w_res = $signed(i_a) >>> i_b;
      ALU_SLA:  w_res = (i_b << 1) + i_a;
      ALU_OR:   w_res = i_a | i_b;
      ALU_NAND: w_res = ~(i_a & i_b);
      default:  w_res = '0;
    endcase
  end

  always_ff @(negedge i_clk) begin
    r_out   <= w_res;
    r_zerof <= (w_res == '0);
  end

  assign o_out   = r_out;
  assign o_zerof = r_zerof;

endmodule

// File: rtl/regfile_8x16.sv
// 8x16 register file: two operand read ports, one debug read port and one
// synchronous write port. R0 always reads zero and ignores writes.
module regfile_8x16
  import alu_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [RA_W-1:0]   i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [RA_W-1:0]   i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [RA_W-1:0]   i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b,
  input  logic [RA_W-1:0]   i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data
);

  logic [DATA_W-1:0] r_mem [2**RA_W];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 2**RA_W; k++) r_mem[k] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = (i_raddr_a  == '0) ? '0 : r_mem[i_raddr_a];
  assign o_rdata_b  = (i_raddr_b  == '0) ? '0 : r_mem[i_raddr_b];
  assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_ctrl_seq.sv
// Four-state instruction sequencer: accepts an instruction, reads operands,
// drives the ALU, writes the result back and pulses o_done.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_instr_valid,
  output logic              o_instr_ready,
  input  logic [DATA_W-1:0] i_instr,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic [2:0]        o_alu_op,
  input  logic [DATA_W-1:0] i_alu_out,
  input  logic              i_alu_zerof,
  output logic              o_done,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero,
  output logic              o_illegal,
  input  logic [RA_W-1:0]   i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data
);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [2:0]        r_alu_op;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_illegal;

  logic [3:0]        w_opcode;
  logic              w_is_alu;
  logic [DATA_W-1:0] w_rdata_a;
  logic [DATA_W-1:0] w_rdata_b;
  logic [DATA_W-1:0] w_exec_result;
  logic              w_exec_zero;
  logic              w_exec_illegal;
  logic              w_exec_write;
  logic              w_we;

  assign w_opcode = r_instr[OPC_MSB:OPC_LSB];
  assign w_is_alu = ~w_opcode[3];

  regfile_8x16 u_regfile (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_we       (w_we),
    .i_waddr    (r_instr[RD_MSB:RD_LSB]),
    .i_wdata    (w_exec_result),
    .i_raddr_a  (r_instr[RS_MSB:RS_LSB]),
    .o_rdata_a  (w_rdata_a),
    .i_raddr_b  (r_instr[RT_MSB:RT_LSB]),
    .o_rdata_b  (w_rdata_b),
    .i_dbg_addr (i_dbg_addr),
    .o_dbg_data (o_dbg_data)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_instr_valid) w_next = DECODE;
      DECODE:  w_next = EXEC;
      EXEC:    w_next = WB;
      WB:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // What EXEC commits depends only on the opcode class; only ALU ops consume i_alu_*.
  always_comb begin
    w_exec_result  = '0;
    w_exec_zero    = 1'b0;
    w_exec_illegal = 1'b0;
    w_exec_write   = 1'b0;
    if (w_is_alu) begin
      w_exec_result = i_alu_out;
      w_exec_zero   = i_alu_zerof;
      w_exec_write  = 1'b1;
    end else if (w_opcode == OP_NOP) begin
      w_exec_zero = 1'b1;
    end else if (w_opcode == OP_LI) begin
      w_exec_result = sext9(r_instr[IMM_MSB:IMM_LSB]);
      w_exec_zero   = (w_exec_result == '0);
      w_exec_write  = 1'b1;
    end else begin
      w_exec_illegal = 1'b1;
    end
  end

  assign w_we = (r_state == EXEC) && w_exec_write;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_instr   <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= ALU_ADD;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && i_instr_valid) r_instr <= i_instr;
      if (r_state == DECODE && w_is_alu) begin
        r_alu_a  <= w_rdata_a;
        r_alu_b  <= w_rdata_b;
        r_alu_op <= w_opcode[2:0];
      end
      if (r_state == EXEC) begin
        r_result  <= w_exec_result;
        r_zero    <= w_exec_zero;
        r_illegal <= w_exec_illegal;
      end
    end
  end

  assign o_instr_ready = (r_state == IDLE);
  assign o_done        = (r_state == WB);
  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_op      = r_alu_op;
  assign o_result      = r_result;
  assign o_zero        = r_zero;
  assign o_illegal     = r_illegal & (r_state == WB);

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed self-checking bench for alu_ctrl_seq driving the real negedge ALU.
module tb_alu_ctrl_seq;

  logic        clk = 1'b0;
  logic        rstN;
  logic        instrValid;
  logic        instrReady;
  logic [15:0] instr;
  logic [15:0] aluA;
  logic [15:0] aluB;
  logic [2:0]  aluOp;
  logic [15:0] aluOut;
  logic        aluZerof;
  logic        done;
  logic [15:0] result;
  logic        zero;
  logic        illegal;
  logic [2:0]  dbgAddr;
  logic [15:0] dbgData;

  int nAsserts = 0;
  int nFails   = 0;

  always #5 clk = ~clk;

  alu_ctrl_seq dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_instr_valid (instrValid),
    .o_instr_ready (instrReady),
    .i_instr       (instr),
    .o_alu_a       (aluA),
    .o_alu_b       (aluB),
    .o_alu_op      (aluOp),
    .i_alu_out     (aluOut),
    .i_alu_zerof   (aluZerof),
    .o_done        (done),
    .o_result      (result),
    .o_zero        (zero),
    .o_illegal     (illegal),
    .i_dbg_addr    (dbgAddr),
    .o_dbg_data    (dbgData)
  );

  alu16 u_alu (
    .i_clk   (clk),
    .i_a     (aluA),
    .i_b     (aluB),
    .i_op    (aluOp),
    .o_out   (aluOut),
    .o_zerof (aluZerof)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives one instruction and returns #1 after the accepting posedge.
  task automatic applyStimulus(input logic [15:0] ins);
    int waited;
    @(negedge clk);
    instrValid = 1'b1;
    instr      = ins;
    waited     = 0;
    while (!instrReady && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!instrReady) checkOutput("handshake_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    instrValid = 1'b0;
  endtask

  task automatic waitDone(output int lat);
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    if (!done) lat = 99;
  endtask

  logic [15:0] queueInstr [4];
  int          acceptAt [4];
  int          lat;
  int          idx;
  int          doneCnt;
  int          dblDone;
  logic        prevDone;
  logic        willAccept;

  initial begin
    rstN       = 1'b0;
    instrValid = 1'b0;
    instr      = 16'h0000;
    dbgAddr    = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready",   instrReady, 1);
    checkOutput("rst_done",    done, 0);
    checkOutput("rst_result",  result, 0);
    checkOutput("rst_zero",    zero, 0);
    checkOutput("rst_illegal", illegal, 0);
    checkOutput("rst_alu_a",   aluA, 0);
    checkOutput("rst_alu_b",   aluB, 0);
    checkOutput("rst_alu_op",  aluOp, 0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_ready", instrReady, 1);

    $display("[TB] LI r1,5 ; LI r2,3 ; ADD r3,r1,r2");
    applyStimulus(16'h9205);
    checkOutput("li_r1_decode_done", done, 0);
    waitDone(lat);
    checkOutput("li_r1_latency", lat, 2);
    checkOutput("li_r1_result", result, 16'h0005);
    applyStimulus(16'h9403);
    waitDone(lat);
    checkOutput("li_r2_result", result, 16'h0003);
    applyStimulus(16'h0650);
    waitDone(lat);
    checkOutput("add_latency", lat, 2);
    checkOutput("add_alu_a", aluA, 16'h0005);
    checkOutput("add_alu_b", aluB, 16'h0003);
    checkOutput("add_alu_op", aluOp, 3'd0);
    checkOutput("add_result", result, 16'h0008);
    checkOutput("add_zero", zero, 0);
    checkOutput("add_illegal", illegal, 0);
    dbgAddr = 3'd3;
    #1;
    checkOutput("add_dbg_r3", dbgData, 16'h0008);
    @(posedge clk);
    #1;
    checkOutput("done_one_cycle", done, 0);
    checkOutput("result_held", result, 16'h0008);

    $display("[TB] SUB r4,r1,r1");
    applyStimulus(16'h1848);
    waitDone(lat);
    checkOutput("sub_result", result, 16'h0000);
    checkOutput("sub_zero", zero, 1);

    $display("[TB] LI r5,0x1FC ; LI r6,1 ; SAR r7,r5,r6");
    applyStimulus(16'h9BFC);
    waitDone(lat);
    checkOutput("li_r5_result", result, 16'hFFFC);
    checkOutput("li_r5_zero", zero, 0);
    applyStimulus(16'h9C01);
    waitDone(lat);
    checkOutput("li_keeps_alu_a", aluA, 16'h0005);
    checkOutput("li_keeps_alu_op", aluOp, 3'd1);
    applyStimulus(16'h4F70);
    waitDone(lat);
    checkOutput("sar_alu_a", aluA, 16'hFFFC);
    checkOutput("sar_alu_b", aluB, 16'h0001);
    checkOutput("sar_alu_op", aluOp, 3'd4);
    checkOutput("sar_result", result, 16'hFFFE);

    $display("[TB] ADD r0 ; illegal ; NOP");
    applyStimulus(16'h0050);
    waitDone(lat);
    checkOutput("add_r0_result", result, 16'h0008);
    dbgAddr = 3'd0;
    #1;
    checkOutput("add_r0_dbg", dbgData, 16'h0000);
    applyStimulus(16'hF000);
    waitDone(lat);
    checkOutput("illegal_flag", illegal, 1);
    checkOutput("illegal_result", result, 16'h0000);
    checkOutput("illegal_zero", zero, 0);
    dbgAddr = 3'd1;
    #1;
    checkOutput("illegal_keeps_r1", dbgData, 16'h0005);
    dbgAddr = 3'd7;
    #1;
    checkOutput("illegal_keeps_r7", dbgData, 16'hFFFE);
    applyStimulus(16'h8000);
    waitDone(lat);
    checkOutput("nop_result", result, 16'h0000);
    checkOutput("nop_zero", zero, 1);
    checkOutput("nop_illegal", illegal, 0);

    $display("[TB] debug read timing around writeback");
    dbgAddr = 3'd4;
    applyStimulus(16'h980A);
    @(posedge clk);
    #1;
    checkOutput("dbg_exec_old", dbgData, 16'h0000);
    @(posedge clk);
    #1;
    checkOutput("dbg_wb_done", done, 1);
    checkOutput("dbg_wb_new", dbgData, 16'h000A);

    $display("[TB] SLA and SHL");
    applyStimulus(16'h5450);
    waitDone(lat);
    checkOutput("sla_alu_op", aluOp, 3'd5);
    checkOutput("sla_result", result, 16'h000B);
    applyStimulus(16'h2390);
    waitDone(lat);
    checkOutput("shl_alu_a", aluA, 16'h0001);
    checkOutput("shl_alu_b", aluB, 16'h000B);
    checkOutput("shl_result", result, 16'h0016);

    $display("[TB] back-to-back with valid held high");
    queueInstr[0] = 16'h9201;
    queueInstr[1] = 16'h9402;
    queueInstr[2] = 16'h9604;
    queueInstr[3] = 16'h6898;
    idx = 0; doneCnt = 0; dblDone = 0; prevDone = 1'b0;
    for (int c = 0; c < 4; c++) acceptAt[c] = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (idx < 4) begin
        instrValid = 1'b1;
        instr      = queueInstr[idx];
      end else begin
        instrValid = 1'b0;
      end
      willAccept = instrValid && instrReady;
      @(posedge clk);
      if (willAccept) begin
        acceptAt[idx] = c;
        idx++;
      end
      #1;
      if (done) begin
        doneCnt++;
        if (prevDone) dblDone++;
      end
      prevDone = done;
    end
    instrValid = 1'b0;
    checkOutput("b2b_accepted", idx, 4);
    checkOutput("b2b_gap01", acceptAt[1] - acceptAt[0], 4);
    checkOutput("b2b_gap12", acceptAt[2] - acceptAt[1], 4);
    checkOutput("b2b_gap23", acceptAt[3] - acceptAt[2], 4);
    checkOutput("b2b_done_count", doneCnt, 4);
    checkOutput("b2b_done_double", dblDone, 0);
    checkOutput("b2b_last_result", result, 16'h0006);
    dbgAddr = 3'd3;
    #1;
    checkOutput("b2b_r3", dbgData, 16'h0004);
    dbgAddr = 3'd4;
    #1;
    checkOutput("b2b_r4", dbgData, 16'h0006);

    $display("[TB] reset during EXEC of ADD r3,r1,r2");
    applyStimulus(16'h0650);
    @(posedge clk);
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("abort_ready", instrReady, 1);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_result", result, 0);
    checkOutput("abort_alu_a", aluA, 0);
    checkOutput("abort_alu_op", aluOp, 0);
    dbgAddr = 3'd3;
    #1;
    checkOutput("abort_r3_cleared", dbgData, 0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_release_ready", instrReady, 1);
    checkOutput("abort_release_done", done, 0);
    @(posedge clk);
    #1;
    checkOutput("abort_no_late_done", done, 0);
    checkOutput("abort_r3_still_zero", dbgData, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
